pipeline_stall_responder: RTL and testbench
===========================================

// Module: pipeline_stall_responder
// PURPOSE
//  Consumer side of the hazard-detection interface. Owns the fetch-stage PC register, the IF/ID
//  pipeline register and the ID/EX control register, and acts on PCWrite / IF_IDWrite /
//  ID_EXRegMuxCon (hold PC, hold IF/ID, inject bubble). Also handles branch flush, checks that the
//  stall signals are coherent, and keeps stall statistics. Sits between instruction memory and decode.
// PARAMETERS
//  PC_WIDTH    32  PC / branch-target width
//  INSTR_WIDTH 32  instruction width
//  CTRL_WIDTH  9   ID/EX control bundle width (RegDst, ALUOp, MemRead, etc.)
//  RESET_PC    0   PC value after reset
//  CNT_WIDTH   16  statistics counter width
//  MAX_STALL   8   consecutive stall cycles that raise StallTimeout
// PORTS
//  Clk             in   1            rising-edge clock
//  Reset           in   1            asynchronous, active-high
//  PCWrite         in   1            from hazard unit; 1 = PC may advance
//  IF_IDWrite      in   1            from hazard unit; 1 = IF/ID may load
//  ID_EXRegMuxCon  in   1            from hazard unit; 1 = insert bubble into ID/EX
//  Flush           in   1            branch taken, resolved in ID
//  BranchTarget    in   PC_WIDTH     PC to load on Flush
//  Instruction     in   INSTR_WIDTH  IMEM data at address PC
//  ControlIn       in   CTRL_WIDTH   control-unit output for the instruction in IF/ID
//  PC              out  PC_WIDTH     current fetch address
//  IF_IDPC         out  PC_WIDTH     PC+4 of the instruction held in IF/ID
//  IF_IDInstr      out  INSTR_WIDTH  instruction held in IF/ID
//  IF_IDValid      out  1            IF/ID holds a real instruction
//  ID_EXControl    out  CTRL_WIDTH   registered control bundle, or 0 for a bubble
//  ID_EXValid      out  1            ID/EX holds a real instruction
//  StallActive     out  1            FSM is in STALL
//  StallCount      out  CNT_WIDTH    total stall cycles; saturates at all-ones
//  BubbleCount     out  CNT_WIDTH    total bubbles injected (stall or invalid IF/ID); saturating
//  StallTimeout    out  1            sticky; a run of MAX_STALL consecutive stall cycles occurred
//  ProtocolError   out  1            sticky; incoherent hazard inputs were seen
// BEHAVIOUR
//  Reset (async, any cycle, mid-stall included):
//   - PC=RESET_PC.
//   - IF_IDPC=0, IF_IDInstr=0 (NOP), IF_IDValid=0.
//   - ID_EXControl=0, ID_EXValid=0.
//   - FSM=RUN. All counters and sticky flags = 0.
//  All outputs are registered. Every input takes effect on the next rising edge (1-cycle latency).
//  PC (priority order):
//   - Flush: PC <= BranchTarget.
//   - else PCWrite: PC <= PC+4 (wraps modulo 2^PC_WIDTH).
//   - else hold.
//  IF/ID (priority order):
//   - Flush: Instr <= 0, Valid <= 0, IF_IDPC <= 0. Flush overrides IF_IDWrite=0.
//   - else IF_IDWrite: Instr <= Instruction, IF_IDPC <= PC+4, Valid <= 1.
//   - else hold all three.
//  ID/EX:
//   - If ID_EXRegMuxCon=1 or IF_IDValid=0: Control <= 0, Valid <= 0, and BubbleCount++ (saturating).
//   - else Control <= ControlIn, Valid <= 1.
//   - Flush does not bubble ID/EX; the branch itself proceeds.
//  Coherence rule: legal iff PCWrite==IF_IDWrite and ID_EXRegMuxCon==~PCWrite.
//   - Any violation at an edge sets ProtocolError, which holds until Reset.
//   - On a violation, the datapath still obeys each signal individually.
//  FSM, states RUN and STALL:
//   - RUN->STALL on an edge with ID_EXRegMuxCon=1.
//   - STALL->RUN on an edge with ID_EXRegMuxCon=0.
//   - Flush does not change state.
//   - StallActive = (state==STALL).
//  Counters:
//   - StallCount++ on every edge with ID_EXRegMuxCon=1; saturates.
//   - An internal run counter increments on each such edge and clears on an edge with ID_EXRegMuxCon=0.
//   - When the run counter reaches MAX_STALL, StallTimeout=1 (sticky) and the run counter holds.
//  Simultaneous events: Flush together with a stall loads PC and clears IF/ID, and ID/EX still bubbles.
// TESTING
//  1 Reset, then PCWrite=IF_IDWrite=1, MuxCon=0, Instruction=0x8C080004, 3 clks
//    -> PC=12; IF_IDInstr=0x8C080004; IF_IDPC=12; Valid=1.
//  2 Apply a 1-cycle stall (0,0,1) with ControlIn=0x1FF
//    -> PC, IF/ID held; ID_EXControl=0; ID_EXValid=0; StallActive=1; StallCount=1; BubbleCount=1.
//  3 Flush=1 with BranchTarget=0x40 during a stall
//    -> PC=0x40; IF_IDInstr=0; IF_IDValid=0; next cycle ID/EX bubbles because IF_IDValid=0.
//  4 Hold the stall for 8 consecutive clks (MAX_STALL=8)
//    -> StallTimeout=1, and it stays 1 after the stall is released.
//  5 Drive PCWrite=1, IF_IDWrite=0, MuxCon=0
//    -> ProtocolError=1 (sticky); PC advances by 4; IF/ID held.
//  6 Assert Reset asynchronously, mid-clock, during a stall
//    -> all outputs return immediately to their reset values; PC=RESET_PC; counters and flags 0.

Source files
------------

// File: rtl/pipeline_stall_responder.sv
// pipeline_stall_responder
// Consumer side of the hazard-detection interface. Owns the fetch PC, the
// IF/ID register and the ID/EX control register. It acts on the hazard unit's
// hold and bubble requests, applies branch flushes, flags incoherent hazard
// inputs, and keeps stall statistics.
//
// Valid semantics: IF_IDValid / ID_EXValid are high when the stage register
// holds a real instruction. They are low for a NOP or bubble. There is no
// back-pressure path: the hazard inputs are commands that take effect on the
// next rising edge, and every output is registered.
module pipeline_stall_responder #(
   parameter int                    PC_WIDTH    = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    CTRL_WIDTH  = 9,
   parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
   parameter int                    CNT_WIDTH   = 16,
   parameter int                    MAX_STALL   = 8
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   PCWrite,
   input  logic                   IF_IDWrite,
   input  logic                   ID_EXRegMuxCon,
   input  logic                   Flush,
   input  logic [PC_WIDTH-1:0]    BranchTarget,
   input  logic [INSTR_WIDTH-1:0] Instruction,
   input  logic [CTRL_WIDTH-1:0]  ControlIn,
   output logic [PC_WIDTH-1:0]    PC,
   output logic [PC_WIDTH-1:0]    IF_IDPC,
   output logic [INSTR_WIDTH-1:0] IF_IDInstr,
   output logic                   IF_IDValid,
   output logic [CTRL_WIDTH-1:0]  ID_EXControl,
   output logic                   ID_EXValid,
   output logic                   StallActive,
   output logic [CNT_WIDTH-1:0]   StallCount,
   output logic [CNT_WIDTH-1:0]   BubbleCount,
   output logic                   StallTimeout,
   output logic                   ProtocolError
);

   localparam int                  RUN_W    = $clog2(MAX_STALL + 1);
   localparam logic [RUN_W-1:0]    RUN_MAX  = RUN_W'(MAX_STALL);
   localparam logic [RUN_W-1:0]    RUN_LAST = RUN_W'(MAX_STALL - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [RUN_W-1:0]    run_cnt;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic                bubble;
   logic                incoherent;

   // The PC+4 adder wraps modulo 2^PC_WIDTH.
   assign pc_plus4 = PC + PC_STEP;
   // A bubble is a hazard request or an empty IF/ID. A flush alone lets the branch proceed.
   assign bubble = ID_EXRegMuxCon | ~IF_IDValid;
   // The holds must agree with each other, and the bubble must be their complement.
   assign incoherent = (PCWrite != IF_IDWrite) | (ID_EXRegMuxCon != ~PCWrite);
   assign StallActive = (state == ST_STALL);

   // Stall FSM state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= ST_RUN;
      else       state <= state_next;
   end

   // Stall FSM next state follows the bubble request. A flush has no effect on it.
   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:   if (ID_EXRegMuxCon)  state_next = ST_STALL;
         ST_STALL: if (!ID_EXRegMuxCon) state_next = ST_RUN;
         default:  state_next = ST_RUN;
      endcase
   end

   // Fetch PC: a flush wins over an advance; otherwise the PC holds.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)        PC <= RESET_PC;
      else if (Flush)   PC <= BranchTarget;
      else if (PCWrite) PC <= pc_plus4;
   end

   // IF/ID register: a flush clears it even when a hold is requested.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         IF_IDPC    <= '0;
         IF_IDInstr <= '0;
         IF_IDValid <= 1'b0;
      end else if (Flush) begin
         IF_IDPC    <= '0;
         IF_IDInstr <= '0;
         IF_IDValid <= 1'b0;
      end else if (IF_IDWrite) begin
         IF_IDPC    <= pc_plus4;
         IF_IDInstr <= Instruction;
         IF_IDValid <= 1'b1;
      end
   end

   // ID/EX control register: a bubble zeroes the bundle and marks the stage empty.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ID_EXControl <= '0;
         ID_EXValid   <= 1'b0;
      end else if (bubble) begin
         ID_EXControl <= '0;
         ID_EXValid   <= 1'b0;
      end else begin
         ID_EXControl <= ControlIn;
         ID_EXValid   <= 1'b1;
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         StallCount  <= '0;
         BubbleCount <= '0;
      end else begin
         if (ID_EXRegMuxCon && StallCount != CNT_MAX) StallCount <= StallCount + CNT_WIDTH'(1);
         if (bubble && BubbleCount != CNT_MAX)        BubbleCount <= BubbleCount + CNT_WIDTH'(1);
      end
   end

   // Consecutive-stall run length. Timeout is raised on the edge that completes MAX_STALL.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         run_cnt      <= '0;
         StallTimeout <= 1'b0;
      end else if (ID_EXRegMuxCon) begin
         if (run_cnt != RUN_MAX) run_cnt <= run_cnt + RUN_W'(1);
         if (run_cnt >= RUN_LAST) StallTimeout <= 1'b1;
      end else begin
         run_cnt <= '0;
      end
   end

   // Sticky flag for any incoherent combination of hazard inputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)           ProtocolError <= 1'b0;
      else if (incoherent) ProtocolError <= 1'b1;
   end

endmodule

// File: tb/tb_pipeline_stall_responder.sv
// tb_pipeline_stall_responder
// Directed bench. A behavioural model is written from the stage rules and is
// compared with the DUT on every falling edge. Literal expectations at key
// points pin the model itself. Counters are narrowed to 4 bits so that
// saturation is reachable.
module tb_pipeline_stall_responder;

   localparam int CW = 4;
   localparam int MAXS = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic        Clk;
   logic        Reset;
   logic        PCWrite, IF_IDWrite, ID_EXRegMuxCon, Flush;
   logic [31:0] BranchTarget, Instruction;
   logic [8:0]  ControlIn;
   logic [31:0] PC, IF_IDPC, IF_IDInstr;
   logic        IF_IDValid, ID_EXValid, StallActive, StallTimeout, ProtocolError;
   logic [8:0]  ID_EXControl;
   logic [CW-1:0] StallCount, BubbleCount;

   int tests = 0;
   int fails = 0;

   pipeline_stall_responder #(
      .PC_WIDTH(32), .INSTR_WIDTH(32), .CTRL_WIDTH(9), .RESET_PC(32'h0),
      .CNT_WIDTH(CW), .MAX_STALL(MAXS)
   ) dut (
      .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
      .ID_EXRegMuxCon(ID_EXRegMuxCon), .Flush(Flush), .BranchTarget(BranchTarget),
      .Instruction(Instruction), .ControlIn(ControlIn), .PC(PC), .IF_IDPC(IF_IDPC),
      .IF_IDInstr(IF_IDInstr), .IF_IDValid(IF_IDValid), .ID_EXControl(ID_EXControl),
      .ID_EXValid(ID_EXValid), .StallActive(StallActive), .StallCount(StallCount),
      .BubbleCount(BubbleCount), .StallTimeout(StallTimeout), .ProtocolError(ProtocolError)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // behavioural model
   logic [31:0] m_pc, m_ifid_pc, m_ifid_instr;
   logic [8:0]  m_ctl;
   bit          m_ifid_valid, m_idex_valid, m_stalled, m_timeout, m_perr;
   int          m_run, m_stall_cnt, m_bub_cnt;

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = 32'h0; m_ifid_valid = 0;
         m_ctl = 9'h0; m_idex_valid = 0; m_stalled = 0;
         m_run = 0; m_stall_cnt = 0; m_bub_cnt = 0; m_timeout = 0; m_perr = 0;
      end else begin
         // ID/EX sees the IF/ID contents from before this edge
         if (ID_EXRegMuxCon || !m_ifid_valid) begin
            m_ctl = 9'h0; m_idex_valid = 0;
            if (m_bub_cnt < CMAX) m_bub_cnt++;
         end else begin
            m_ctl = ControlIn; m_idex_valid = 1;
         end
         // IF/ID captures the address after the one being fetched
         if (Flush) begin
            m_ifid_pc = 0; m_ifid_instr = 0; m_ifid_valid = 0;
         end else if (IF_IDWrite) begin
            m_ifid_pc = m_pc + 32'd4; m_ifid_instr = Instruction; m_ifid_valid = 1;
         end
         if (Flush)        m_pc = BranchTarget;
         else if (PCWrite) m_pc = m_pc + 32'd4;
         // "stalled" means the most recent edge carried a bubble request
         m_stalled = ID_EXRegMuxCon;
         if (ID_EXRegMuxCon) begin
            if (m_stall_cnt < CMAX) m_stall_cnt++;
            m_run++;
            if (m_run >= MAXS) m_timeout = 1;
         end else begin
            m_run = 0;
         end
         if (!(PCWrite == IF_IDWrite && ID_EXRegMuxCon == !PCWrite)) m_perr = 1;
      end
   end

   // scoreboard compare, every falling edge
   always @(negedge Clk) begin
      check("pc", PC, m_pc);
      check("ifid_pc", IF_IDPC, m_ifid_pc);
      check("ifid_instr", IF_IDInstr, m_ifid_instr);
      check("ifid_valid", 32'(IF_IDValid), 32'(m_ifid_valid));
      check("idex_ctl", 32'(ID_EXControl), 32'(m_ctl));
      check("idex_valid", 32'(ID_EXValid), 32'(m_idex_valid));
      check("stall_active", 32'(StallActive), 32'(m_stalled));
      check("stall_cnt", 32'(StallCount), 32'(m_stall_cnt));
      check("bubble_cnt", 32'(BubbleCount), 32'(m_bub_cnt));
      check("timeout", 32'(StallTimeout), 32'(m_timeout));
      check("proto_err", 32'(ProtocolError), 32'(m_perr));
   end

   // driver: apply inputs just after a falling edge, then run one full cycle
   task automatic cyc(input logic pw, input logic iw, input logic mx, input logic fl,
                      input logic [31:0] bt, input logic [31:0] ins, input logic [8:0] ctl);
      PCWrite = pw; IF_IDWrite = iw; ID_EXRegMuxCon = mx; Flush = fl;
      BranchTarget = bt; Instruction = ins; ControlIn = ctl;
      @(negedge Clk);
   endtask

   initial begin
      Reset = 1'b1;
      PCWrite = 0; IF_IDWrite = 0; ID_EXRegMuxCon = 0; Flush = 0;
      BranchTarget = 0; Instruction = 0; ControlIn = 0;
      @(negedge Clk);
      Reset = 1'b0;
      check("rst_pc", PC, 32'h0);
      check("rst_ifid_valid", 32'(IF_IDValid), 32'h0);
      check("rst_idex_valid", 32'(ID_EXValid), 32'h0);
      check("rst_stall_cnt", 32'(StallCount), 32'h0);

      // normal fetch for three cycles
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 32'h0, 32'h8C080004, 9'h0AB);
      check("t1_pc", PC, 32'd12);
      check("t1_ifid_instr", IF_IDInstr, 32'h8C080004);
      check("t1_ifid_pc", IF_IDPC, 32'd12);
      check("t1_ifid_valid", 32'(IF_IDValid), 32'h1);
      check("t1_idex_ctl", 32'(ID_EXControl), 32'h0AB);
      check("t1_bubble_cnt", 32'(BubbleCount), 32'd1);

      // single stall cycle
      cyc(0, 0, 1, 0, 32'h0, 32'hDEADBEEF, 9'h1FF);
      check("t2_pc", PC, 32'd12);
      check("t2_ifid_instr", IF_IDInstr, 32'h8C080004);
      check("t2_idex_ctl", 32'(ID_EXControl), 32'h0);
      check("t2_idex_valid", 32'(ID_EXValid), 32'h0);
      check("t2_stall_active", 32'(StallActive), 32'h1);
      check("t2_stall_cnt", 32'(StallCount), 32'd1);
      check("t2_bubble_cnt", 32'(BubbleCount), 32'd2);

      // flush during a stall
      cyc(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 9'h1FF);
      check("t3_pc", PC, 32'h40);
      check("t3_ifid_instr", IF_IDInstr, 32'h0);
      check("t3_ifid_valid", 32'(IF_IDValid), 32'h0);
      check("t3_stall_active", 32'(StallActive), 32'h1);
      cyc(1, 1, 0, 0, 32'h0, 32'h00000020, 9'h0F0);
      check("t3_idex_valid", 32'(ID_EXValid), 32'h0);
      check("t3_bubble_cnt", 32'(BubbleCount), 32'd4);
      check("t3_pc_after", PC, 32'h44);

      // MAX_STALL consecutive stalls
      for (int i = 0; i < MAXS - 1; i++) cyc(0, 0, 1, 0, 32'h0, 32'h11111111, 9'h1FF);
      check("t4_timeout_early", 32'(StallTimeout), 32'h0);
      cyc(0, 0, 1, 0, 32'h0, 32'h11111111, 9'h1FF);
      check("t4_timeout", 32'(StallTimeout), 32'h1);
      check("t4_stall_cnt", 32'(StallCount), 32'd10);
      check("t4_bubble_cnt", 32'(BubbleCount), 32'd12);
      cyc(1, 1, 0, 0, 32'h0, 32'h22222222, 9'h155);
      check("t4_timeout_sticky", 32'(StallTimeout), 32'h1);
      check("t4_stall_active", 32'(StallActive), 32'h0);
      check("t4_pc", PC, 32'h48);
      check("t4_idex_ctl", 32'(ID_EXControl), 32'h155);

      // incoherent hazard inputs
      cyc(1, 0, 0, 0, 32'h0, 32'h33333333, 9'h0AA);
      check("t5_perr", 32'(ProtocolError), 32'h1);
      check("t5_pc", PC, 32'h4C);
      check("t5_ifid_pc", IF_IDPC, 32'h48);
      check("t5_ifid_instr", IF_IDInstr, 32'h22222222);
      cyc(1, 1, 0, 0, 32'h0, 32'h44444444, 9'h0AA);
      check("t5_perr_sticky", 32'(ProtocolError), 32'h1);
      cyc(0, 1, 0, 0, 32'h0, 32'h55555555, 9'h0CC);
      cyc(1, 1, 1, 0, 32'h0, 32'h66666666, 9'h0DD);

      // asynchronous reset in the middle of a stall
      cyc(0, 0, 1, 0, 32'h0, 32'h77777777, 9'h1FF);
      @(posedge Clk);
      #1;
      check("t6_stall_before", 32'(StallActive), 32'h1);
      #1;
      Reset = 1'b1;
      #1;
      check("t6_pc", PC, 32'h0);
      check("t6_ifid_valid", 32'(IF_IDValid), 32'h0);
      check("t6_ifid_instr", IF_IDInstr, 32'h0);
      check("t6_idex_valid", 32'(ID_EXValid), 32'h0);
      check("t6_stall_active", 32'(StallActive), 32'h0);
      check("t6_stall_cnt", 32'(StallCount), 32'h0);
      check("t6_bubble_cnt", 32'(BubbleCount), 32'h0);
      check("t6_timeout", 32'(StallTimeout), 32'h0);
      check("t6_perr", 32'(ProtocolError), 32'h0);
      @(negedge Clk);
      Reset = 1'b0;

      // PC wrap through a flush to the top of the address space
      cyc(1, 1, 0, 1, 32'hFFFFFFFC, 32'h0, 9'h0);
      check("wrap_pc_top", PC, 32'hFFFFFFFC);
      cyc(1, 1, 0, 0, 32'h0, 32'h00001234, 9'h011);
      check("wrap_pc", PC, 32'h0);
      check("wrap_ifid_pc", IF_IDPC, 32'h0);
      check("wrap_ifid_instr", IF_IDInstr, 32'h00001234);

      // long stall saturates both counters
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 32'h0, 32'h0, 9'h1FF);
      check("sat_stall_cnt", 32'(StallCount), 32'(CMAX));
      check("sat_bubble_cnt", 32'(BubbleCount), 32'(CMAX));
      check("sat_timeout", 32'(StallTimeout), 32'h1);
      cyc(1, 1, 0, 0, 32'h0, 32'h99999999, 9'h123);
      cyc(1, 1, 0, 0, 32'h0, 32'hAAAAAAAA, 9'h124);
      check("end_idex_ctl", 32'(ID_EXControl), 32'h124);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
